// File: rtl/dram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// dram_wr_arbiter
//
// Write-port controller for a single-write-port distributed RAM (BHT, BTB,
// tag array, ...). Two requesters share the one write port under round-robin
// arbitration. A clear sweep zeroes every entry on a flush request, and also
// after reset when the optional feature below is enabled. Every RAM write-port
// output comes straight from a flop, so the RAM sees glitch-free strobes.
//
// Optional feature (compile-time macro DRAM_WR_ARBITER_INIT_SWEEP_EN):
//   defined   : reset lands in SWEEP, so the RAM is zeroed after every reset.
//   undefined : reset lands in RUN; the RAM keeps its power-up contents until
//               the first flush_i.
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   flush_i       in   pulse: start or restart a clear sweep
//   busy_o        out  sweep in progress (state == SWEEP); requesters blocked
//   req0_valid_i  in   requester 0 write request
//   req0_addr_i   in   requester 0 address   [AWDTH]
//   req0_data_i   in   requester 0 data      [XLEN]
//   req0_ready_o  out  requester 0 granted this cycle (combinational)
//   req1_valid_i  in   requester 1 write request
//   req1_addr_i   in   requester 1 address   [AWDTH]
//   req1_data_i   in   requester 1 data      [XLEN]
//   req1_ready_o  out  requester 1 granted this cycle (combinational)
//   ram_we_o      out  RAM write enable      (registered)
//   ram_addr_o    out  RAM write address     (registered)
//   ram_data_o    out  RAM write data        (registered)
//
// Handshake: a requester raises reqN_valid_i and holds valid, addr and data
// stable until it sees reqN_ready_o high in the same cycle; that cycle is the
// transfer. Ready is a pure function of state, flush_i, both valids and the
// round-robin pointer -- never of ram_we_o -- so a requester may be granted
// every cycle. The accepted write shows up on the RAM port one edge later.
//
// Debug visibility: the FSM has two states and busy_o is exactly
// (state == SWEEP), so busy_o is the state observation point.
// -----------------------------------------------------------------------------
module dram_wr_arbiter #(
  parameter int ENTRY_NUM = 32,
  parameter int XLEN      = 32,
  parameter int AWDTH     = $clog2(ENTRY_NUM)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             busy_o,
  input  logic             req0_valid_i,
  input  logic [AWDTH-1:0] req0_addr_i,
  input  logic [XLEN-1:0]  req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [AWDTH-1:0] req1_addr_i,
  input  logic [XLEN-1:0]  req1_data_i,
  output logic             req1_ready_o,
  output logic             ram_we_o,
  output logic [AWDTH-1:0] ram_addr_o,
  output logic [XLEN-1:0]  ram_data_o
);

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

`ifdef DRAM_WR_ARBITER_INIT_SWEEP_EN
  localparam state_e RESET_STATE = SWEEP;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  // Last sweep address; ENTRY_NUM need not be a power of two, so the sweep
  // end is an explicit compare rather than counter wrap.
  localparam logic [AWDTH-1:0] LAST_ADDR = AWDTH'(ENTRY_NUM - 1);

  state_e           state_q, state_d;
  logic [AWDTH-1:0] cnt_q, cnt_d;
  // Round-robin pointer: 0 = req0 was granted last, 1 = req1 was granted last.
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [AWDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             gnt0, gnt1;

  // ---------------------------------------------------------------------------
  // State and write-port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, arbitration and next write-port values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = addr_q;   // address/data hold when no write is issued
    data_d  = data_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    case (state_q)
      SWEEP: begin
        // The current entry is always written; a flush only rewinds the
        // counter so a full ENTRY_NUM writes follow from this point.
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + AWDTH'(1);
        end
      end

      RUN: begin
        if (flush_i) begin
          // No grant in the flush cycle; the sweep starts on the next edge.
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          // On contention the requester that did not win last time goes.
          gnt0 = req0_valid_i & (~req1_valid_i | last_q);
          gnt1 = req1_valid_i & (~req0_valid_i | ~last_q);
          if (gnt0) begin
            we_d   = 1'b1;
            addr_d = req0_addr_i;
            data_d = req0_data_i;
            last_d = 1'b0;
          end else if (gnt1) begin
            we_d   = 1'b1;
            addr_d = req1_addr_i;
            data_d = req1_data_i;
            last_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o       = (state_q == SWEEP);
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign ram_we_o     = we_q;
  assign ram_addr_o   = addr_q;
  assign ram_data_o   = data_q;

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_wr_arbiter
//
// Self-checking bench for dram_wr_arbiter. The reference model tracks the
// write port in terms of "writes left in the current sweep", "next sweep
// address" and "which requester wins a tie", and predicts readies, busy and
// the registered RAM outputs for every cycle. Inputs are driven on the falling
// edge; outputs are sampled 1 time unit later (registered outputs reflect the
// previous rising edge, readies reflect the freshly driven inputs).
// -----------------------------------------------------------------------------
module tb_dram_wr_arbiter;

  localparam int ENTRY_NUM = 32;
  localparam int XLEN      = 32;
  localparam int AWDTH     = $clog2(ENTRY_NUM);
  localparam int OW        = 4 + AWDTH + XLEN;

`ifdef DRAM_WR_ARBITER_INIT_SWEEP_EN
  localparam bit INIT_SWEEP = 1'b1;
`else
  localparam bit INIT_SWEEP = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             busy_o;
  logic             req0_valid_i, req1_valid_i;
  logic [AWDTH-1:0] req0_addr_i, req1_addr_i;
  logic [XLEN-1:0]  req0_data_i, req1_data_i;
  logic             req0_ready_o, req1_ready_o;
  logic             ram_we_o;
  logic [AWDTH-1:0] ram_addr_o;
  logic [XLEN-1:0]  ram_data_o;

  always #5 clk_i = ~clk_i;

  dram_wr_arbiter #(
    .ENTRY_NUM (ENTRY_NUM),
    .XLEN      (XLEN)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .req0_valid_i (req0_valid_i),
    .req0_addr_i  (req0_addr_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_addr_i  (req1_addr_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o)
  );

  // ---------------------------------------------------------------------------
  // Counters, reference model state, scoreboard
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;

  int               m_left;   // writes remaining in the current sweep (0 = not sweeping)
  int               m_next;   // next address the sweep will write
  int               m_pref;   // requester that wins if both are valid
  logic             m_we;     // predicted registered RAM outputs
  logic [AWDTH-1:0] m_addr;
  logic [XLEN-1:0]  m_data;

  logic [OW-1:0]    obs, exp_v;
  logic             last_r0, last_r1;   // predicted grants of the latest tick

  logic             sb_en = 1'b0;
  logic [AWDTH+XLEN-1:0] exp_q[$];

  task automatic model_reset();
    m_left = INIT_SWEEP ? ENTRY_NUM : 0;
    m_next = 0;
    m_pref = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic drive_idle();
    flush_i      = 1'b0;
    req0_valid_i = 1'b0;
    req0_addr_i  = '0;
    req0_data_i  = '0;
    req1_valid_i = 1'b0;
    req1_addr_i  = '0;
    req1_data_i  = '0;
  endtask

  // One clock: drive inputs, sample outputs, predict them, advance the model.
  task automatic tick(input logic v0, input logic [AWDTH-1:0] a0, input logic [XLEN-1:0] d0,
                      input logic v1, input logic [AWDTH-1:0] a1, input logic [XLEN-1:0] d1,
                      input logic fl);
    logic e_busy, e_r0, e_r1;
    @(negedge clk_i);
    req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
    req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    flush_i      = fl;
    #1;
    obs    = {busy_o, req0_ready_o, req1_ready_o, ram_we_o, ram_addr_o, ram_data_o};
    e_busy = (m_left > 0);
    e_r0   = 1'b0;
    e_r1   = 1'b0;
    if (!e_busy && !fl) begin
      if (v0 && (!v1 || m_pref == 0)) e_r0 = 1'b1;
      else if (v1)                     e_r1 = 1'b1;
    end
    exp_v   = {e_busy, e_r0, e_r1, m_we, m_addr, m_data};
    last_r0 = e_r0;
    last_r1 = e_r1;
    if (e_busy) begin
      m_we   = 1'b1;
      m_addr = AWDTH'(m_next);
      m_data = '0;
      if (fl) begin
        m_next = 0;
        m_left = ENTRY_NUM;
      end else begin
        m_next = m_next + 1;
        m_left = m_left - 1;
      end
    end else if (fl) begin
      m_we   = 1'b0;
      m_next = 0;
      m_left = ENTRY_NUM;
    end else if (e_r0) begin
      m_we = 1'b1; m_addr = a0; m_data = d0; m_pref = 1;
    end else if (e_r1) begin
      m_we = 1'b1; m_addr = a1; m_data = d1; m_pref = 0;
    end else begin
      m_we = 1'b0;
    end
    if (sb_en && m_we) exp_q.push_back({m_addr, m_data});
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) begin
      @(negedge clk_i); #1;
      obs   = {busy_o, req0_ready_o, req1_ready_o, ram_we_o, ram_addr_o, ram_data_o};
      exp_v = {(m_left > 0), 1'b0, 1'b0, m_we, m_addr, m_data};
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_values: got %h want %h", obs, exp_v);
      end
    end
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
  endtask

  // Idle until any sweep in progress has finished and its last write is seen.
  task automatic test_sweep(input string name);
    int guard;
    guard = 0;
    while ((m_left > 0 || m_we) && guard < 3 * ENTRY_NUM) begin
      tick(0, '0, '0, 0, '0, '0, 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h want %h", name, guard, obs, exp_v);
      end
      guard++;
    end
    n_vec++;
    if (guard >= 3 * ENTRY_NUM) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles want < %0d", name, guard, 3 * ENTRY_NUM);
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tick(1, AWDTH'(3), XLEN'('hA), 1, AWDTH'(5), XLEN'('hB), 0);
      else       tick(0, '0, '0, 0, '0, '0, 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL alternate cyc %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_same_addr();
    logic p0, p1;
    // Sequential writes to one address: 0x55 from req1, then 0x66 from req0.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       tick(0, '0, '0, 1, AWDTH'(7), XLEN'('h55), 0);
        1:       tick(1, AWDTH'(7), XLEN'('h66), 0, '0, '0, 0);
        default: tick(0, '0, '0, 0, '0, '0, 0);
      endcase
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL same_addr_seq cyc %0d: got %h want %h", i, obs, exp_v);
      end
    end
    // Simultaneous writes to one address: loser stays valid and goes next.
    p0 = 1'b1;
    p1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(p0, AWDTH'(9), XLEN'('h1111), p1, AWDTH'(9), XLEN'('h2222), 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL same_addr_both cyc %0d: got %h want %h", i, obs, exp_v);
      end
      if (last_r0) p0 = 1'b0;
      if (last_r1) p1 = 1'b0;
    end
  endtask

  task automatic test_first_grant();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) tick(1, AWDTH'(1), XLEN'('h9), 0, '0, '0, 0);
      else        tick(0, '0, '0, 0, '0, '0, 0);
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL first_grant cyc %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_flush_with_req();
    int  guard;
    logic fl;
    guard = 0;
    fl    = 1'b1;
    last_r0 = 1'b0;
    while (!last_r0 && guard < 3 * ENTRY_NUM) begin
      tick(1, AWDTH'(12), XLEN'('hC0FFEE), 0, '0, '0, fl);
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL flush_req cyc %0d: got %h want %h", guard, obs, exp_v);
      end
      fl = 1'b0;
      guard++;
    end
    n_vec++;
    if (guard != ENTRY_NUM + 2) begin
      n_fail++;
      $display("FAIL flush_req_grant_cycle: got %0d want %0d", guard, ENTRY_NUM + 2);
    end
    test_sweep("flush_req_tail");
  endtask

  task automatic test_flush_mid_sweep();
    for (int i = 0; i < 12; i++) begin
      tick(0, '0, '0, 0, '0, '0, (i == 0) || (i == 11));
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL flush_mid cyc %0d: got %h want %h", i, obs, exp_v);
      end
    end
    test_sweep("flush_mid_tail");
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 22; i++) begin
      tick(0, '0, '0, 0, '0, '0, (i == 0));
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, obs, exp_v);
      end
    end
    drive_idle();
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    obs   = {busy_o, req0_ready_o, req1_ready_o, ram_we_o, ram_addr_o, ram_data_o};
    exp_v = {(m_left > 0), 1'b0, 1'b0, m_we, m_addr, m_data};
    n_vec++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want %h", obs, exp_v);
    end
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    test_sweep("reset_mid_resweep");
  endtask

  task automatic test_random();
    logic             p0, p1, fl;
    logic [AWDTH-1:0] a0, a1;
    logic [XLEN-1:0]  d0, d1;
    logic [AWDTH+XLEN-1:0] got_w, want_w;
    p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    exp_q.delete();
    sb_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1; a0 = AWDTH'($urandom_range(0, ENTRY_NUM - 1)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1; a1 = AWDTH'($urandom_range(0, ENTRY_NUM - 1)); d1 = $urandom;
      end
      fl = ($urandom_range(0, 59) == 0);
      tick(p0, a0, d0, p1, a1, d1, fl);
      n_vec++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_v);
      end
      if (ram_we_o) begin
        got_w = {ram_addr_o, ram_data_o};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_sb_empty cyc %0d: got %h want none", i, got_w);
        end else begin
          want_w = exp_q.pop_front();
          if (got_w !== want_w) begin
            n_fail++;
            $display("FAIL random_sb cyc %0d: got %h want %h", i, got_w, want_w);
          end
        end
      end
      if (last_r0) p0 = 1'b0;
      if (last_r1) p1 = 1'b0;
    end
    sb_en = 1'b0;
    tick(0, '0, '0, 0, '0, '0, 0);
    n_vec++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL random_drain: got %h want %h", obs, exp_v);
    end
    if (ram_we_o && exp_q.size() > 0) void'(exp_q.pop_front());
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_sb_left: got %0d entries want 0", exp_q.size());
    end
    test_sweep("random_tail");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sweep("init_sweep");
    test_alternate();
    test_same_addr();
    test_first_grant();
    test_flush_with_req();
    test_flush_mid_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
